// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared multicycle-MIPS encodings for control, datapath and ALU control
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } mc_state_e;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [1:0] c_srcb_reg     = 2'd0;
  localparam logic [1:0] c_srcb_four    = 2'd1;
  localparam logic [1:0] c_srcb_imm     = 2'd2;
  localparam logic [1:0] c_srcb_imm_sl2 = 2'd3;

  localparam logic [1:0] c_aluop_add   = 2'd0;
  localparam logic [1:0] c_aluop_sub   = 2'd1;
  localparam logic [1:0] c_aluop_funct = 2'd2;

  localparam logic [1:0] c_pcsrc_alu    = 2'd0;
  localparam logic [1:0] c_pcsrc_aluout = 2'd1;
  localparam logic [1:0] c_pcsrc_jump   = 2'd2;

  // Unsupported opcodes park the machine in HALT
  function automatic mc_state_e decode_dispatch(input logic [5:0] op);
    case (op)
      c_op_rtype:       return EXEC;
      c_op_lw, c_op_sw: return MEMADR;
      c_op_beq:         return BRANCH;
      c_op_addi:        return ADDIEX;
      c_op_j:           return JUMP;
      default:          return HALT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_retire_counter.sv
// ============================================================================
// Module      : mc_retire_counter
// Description : Wrapping count of retired instructions
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (inc)
      r_count <= r_count + CNT_W'(1);
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle MIPS main control FSM with retire counter and illegal-op flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  mc_state_e r_state;
  logic      r_illegal;
  logic      w_mem_ok;
  logic      w_retire;

  generate
    if (MEM_HANDSHAKE != 0) begin : g_handshake
      assign w_mem_ok = mem_ready;
    end else begin : g_no_handshake
      assign w_mem_ok = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH:  if (w_mem_ok) r_state <= DECODE;
        DECODE: begin
          r_state <= decode_dispatch(opcode);
          if (decode_dispatch(opcode) == HALT) r_illegal <= 1'b1;
        end
        MEMADR: r_state <= (opcode == c_op_sw) ? MEMWR : MEMRD;
        MEMRD:  if (w_mem_ok) r_state <= MEMWB;
        MEMWR:  if (w_mem_ok) r_state <= FETCH;
        EXEC:   r_state <= ALUWB;
        ADDIEX: r_state <= ADDIWB;
        MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: r_state <= FETCH;
        HALT:   r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Last state of each instruction retires it on the way back to FETCH
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: w_retire = 1'b1;
      MEMWR:                              w_retire = w_mem_ok;
      default:                            w_retire = 1'b0;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = c_srcb_reg;
    alu_op        = c_aluop_add;
    pc_source     = c_pcsrc_alu;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = c_srcb_four;
        ir_write  = w_mem_ok;
        pc_write  = w_mem_ok;
      end
      DECODE: alu_src_b = c_srcb_imm_sl2;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_srcb_imm;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = c_aluop_funct;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = c_aluop_sub;
        pc_write_cond = 1'b1;
        pc_source     = c_pcsrc_aluout;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = c_pcsrc_jump;
      end
      default: ;
    endcase
  end

  mc_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_retire),
    .count (retired)
  );

  assign state      = r_state;
  assign illegal_op = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm driven by directed instruction sequences
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

  localparam int CNT_W = 32;

  localparam logic [5:0] c_lw   = 6'b100011;
  localparam logic [5:0] c_sw   = 6'b101011;
  localparam logic [5:0] c_rt   = 6'b000000;
  localparam logic [5:0] c_addi = 6'b001000;
  localparam logic [5:0] c_beq  = 6'b000100;
  localparam logic [5:0] c_j    = 6'b000010;
  localparam logic [5:0] c_bad  = 6'h3F;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  mc_control_fsm #(
    .MEM_HANDSHAKE (1),
    .CNT_W         (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .illegal_op    (illegal_op),
    .retired       (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb[2], aluop[2], pcsrc[2]}
  logic [15:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  typedef struct packed {
    logic [3:0]       st;
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] ret;
    logic             ill;
    logic [7:0]       tag;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [CNT_W-1:0] exp_ret = '0;
  logic             exp_ill = 1'b0;
  logic [7:0]       tag     = 8'd0;

  // Hand-written strobe table for each state; r is mem_ready for FETCH gating
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic r);
    case (st)
      4'd0:  return {r, 1'b0, 1'b0, 1'b1, 1'b0, r, 4'b0000, 2'd1, 2'd0, 2'd0};
      4'd1:  return {10'b0, 2'd3, 2'd0, 2'd0};
      4'd2:  return {9'b0, 1'b1, 2'd2, 2'd0, 2'd0};
      4'd3:  return {2'b00, 1'b1, 1'b1, 6'b0, 6'd0};
      4'd4:  return {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
      4'd5:  return {2'b00, 1'b1, 1'b0, 1'b1, 5'b0, 6'd0};
      4'd6:  return {9'b0, 1'b1, 2'd0, 2'd2, 2'd0};
      4'd7:  return {7'b0, 1'b1, 1'b1, 1'b0, 6'd0};
      4'd8:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'd0, 2'd1, 2'd1};
      4'd9:  return {9'b0, 1'b1, 2'd2, 2'd0, 2'd0};
      4'd10: return {8'b0, 1'b1, 1'b0, 6'd0};
      4'd11: return {1'b1, 9'b0, 2'd0, 2'd0, 2'd2};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    exp_t x;
    x.st   = st;
    x.ctrl = exp_ctrl(st, rdy);
    x.ret  = exp_ret;
    x.ill  = exp_ill;
    x.tag  = tag;
    q.push_back(x);
    tag = tag + 8'd1;
  endtask

  // One cycle with reset low: drive inputs, post expectation, advance
  task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    reset     = 1'b0;
    mem_ready = rdy;
    opcode    = op;
    push(st, rdy);
    @(posedge clk);
    #1;
  endtask

  // One cycle with reset asserted (asynchronous, takes effect mid-cycle)
  task automatic rstep(input logic rdy);
    reset     = 1'b1;
    mem_ready = rdy;
    exp_ret   = '0;
    exp_ill   = 1'b0;
    push(4'd0, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    exp_ret = exp_ret + CNT_W'(1);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests = n_tests + 4;
      if (state !== e.st) begin
        n_fail = n_fail + 1;
        $display("FAIL state[%0d]: got %0d expected %0d", e.tag, state, e.st);
      end
      if (act_ctrl !== e.ctrl) begin
        n_fail = n_fail + 1;
        $display("FAIL ctrl[%0d] st=%0d: got %04h expected %04h", e.tag, e.st, act_ctrl, e.ctrl);
      end
      if (retired !== e.ret) begin
        n_fail = n_fail + 1;
        $display("FAIL retired[%0d]: got %0d expected %0d", e.tag, retired, e.ret);
      end
      if (illegal_op !== e.ill) begin
        n_fail = n_fail + 1;
        $display("FAIL illegal_op[%0d]: got %0b expected %0b", e.tag, illegal_op, e.ill);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rstep(1'b1);
    rstep(1'b0);

    // lw abandoned by async reset while stalled in MEMRD
    step(4'd0, 1'b1, c_lw);
    step(4'd1, 1'b1, c_lw);
    step(4'd2, 1'b1, c_lw);
    step(4'd3, 1'b0, c_lw);
    rstep(1'b1);
    // full lw: 0,1,2,3,4 then retire
    step(4'd0, 1'b1, c_lw);
    step(4'd1, 1'b1, c_lw);
    step(4'd2, 1'b1, c_lw);
    step(4'd3, 1'b1, c_lw);
    step(4'd4, 1'b1, c_lw);
    retire();
    // sw with 3 stall cycles in MEMWR
    step(4'd0, 1'b1, c_sw);
    step(4'd1, 1'b1, c_sw);
    step(4'd2, 1'b1, c_sw);
    step(4'd5, 1'b0, c_sw);
    step(4'd5, 1'b0, c_sw);
    step(4'd5, 1'b0, c_sw);
    step(4'd5, 1'b1, c_sw);
    retire();
    // FETCH stalled 2 cycles, then R-type with mem_ready ignored afterward
    step(4'd0, 1'b0, c_rt);
    step(4'd0, 1'b0, c_rt);
    step(4'd0, 1'b1, c_rt);
    step(4'd1, 1'b0, c_rt);
    step(4'd6, 1'b0, c_rt);
    step(4'd7, 1'b0, c_rt);
    retire();
    // R-type, addi, beq, j back to back: 14 cycles
    step(4'd0, 1'b1, c_rt);
    step(4'd1, 1'b1, c_rt);
    step(4'd6, 1'b1, c_rt);
    step(4'd7, 1'b1, c_rt);
    retire();
    step(4'd0, 1'b1, c_addi);
    step(4'd1, 1'b1, c_addi);
    step(4'd9, 1'b0, c_addi);
    step(4'd10, 1'b1, c_addi);
    retire();
    step(4'd0, 1'b1, c_beq);
    step(4'd1, 1'b1, c_beq);
    step(4'd8, 1'b0, c_beq);
    retire();
    step(4'd0, 1'b1, c_j);
    step(4'd1, 1'b1, c_j);
    step(4'd11, 1'b0, c_j);
    retire();
    // illegal opcode: HALT sticks for 10 cycles
    step(4'd0, 1'b1, c_bad);
    step(4'd1, 1'b1, c_bad);
    exp_ill = 1'b1;
    for (int i = 0; i < 10; i++) step(4'd12, i[0], c_bad);
    rstep(1'b1);
    step(4'd0, 1'b1, c_j);
    step(4'd1, 1'b1, c_j);
    step(4'd11, 1'b1, c_j);
    retire();
    step(4'd0, 1'b1, c_j);

    @(negedge clk);
    #1;
    n_tests = n_tests + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL declare parameter MEM_HANDSHAKE, default 1, meaning: 1 makes memory states wait on mem_ready; 0 treats mem_ready as always 1.
REQ-002 SHALL declare parameter CNT_W, default 32, meaning: width of retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port opcode, input, 6 bits, instr[31:26] from the instruction register.
REQ-006 SHALL have port mem_ready, input, 1 bit, memory access completes this cycle.
REQ-007 SHALL have outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, all 1 bit, standard multicycle-MIPS control strobes.
REQ-008 SHALL have outputs alu_src_b, alu_op and pc_source, 2 bits each: B-mux select (0 reg, 1 const 4, 2 imm_ext, 3 imm_ext<<2), ALU op class (0 add, 1 sub, 2 funct), next-PC select (0 ALU, 1 ALUOut, 2 jump target).
REQ-009 SHALL have output state, 4 bits, current state encoding for debug.
REQ-010 SHALL have output illegal_op, 1 bit, sticky flag for an unsupported opcode.
REQ-011 SHALL have output retired, CNT_W bits, count of completed instructions.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
REQ-013 FETCH SHALL assert mem_read, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0; ir_write and pc_write are asserted only when mem_ready=1, and the FSM then goes to DECODE; otherwise it stays in FETCH.
REQ-014 DECODE SHALL assert alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute), then dispatch on opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->HALT.
REQ-015 MEMADR SHALL drive alu_src_a=1, alu_src_b=2, alu_op=0, then go to MEMRD for lw or MEMWR for sw.
REQ-016 MEMRD SHALL assert mem_read with iord=1, holding until mem_ready, then go to MEMWB.
REQ-017 MEMWB SHALL assert reg_write with reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-018 MEMWR SHALL assert mem_write with iord=1, holding until mem_ready, then go to FETCH.
REQ-019 EXEC SHALL drive alu_src_a=1, alu_src_b=0, alu_op=2 and go to ALUWB; ALUWB SHALL assert reg_write with reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, then go to FETCH.
REQ-021 ADDIEX SHALL drive alu_src_a=1, alu_src_b=2, alu_op=0 and go to ADDIWB; ADDIWB SHALL assert reg_write with reg_dst=0, then go to FETCH.
REQ-022 JUMP SHALL assert pc_write with pc_source=2, then go to FETCH.
REQ-023 HALT SHALL set illegal_op, assert no strobes, and remain in HALT until reset.
REQ-024 Any strobe not named for a state SHALL be 0 in that state, and the 2-bit selects SHALL be 0 where not specified; all outputs SHALL be a Moore function of state (and mem_ready for the gated strobes in REQ-013).
REQ-025 retired SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
REQ-026 Instruction latencies with mem_ready=1 throughout SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-027 mem_ready SHALL be ignored in states that perform no memory access.

Reset
REQ-028 Reset SHALL force state=FETCH, retired=0 and illegal_op=0 asynchronously; all strobes SHALL then take their FETCH values.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction with no strobe asserted after the reset edge and no count increment.

Structure
REQ-030 The state encoding, opcode constants and the alu_op/alu_src_b/pc_source codes SHALL reside in a shared package, mips_pkg, reused by the datapath and the ALU control.
REQ-031 The block SHALL be flat, except for one optional sub-module, mc_retire_counter, that holds the retired counter.

Verification
REQ-032 lw with mem_ready=1: state sequence 0,1,2,3,4,0; reg_write=1 only in cycle 5 with mem_to_reg=1; retired 0->1.
REQ-033 sw with mem_ready held low 3 cycles in MEMWR: mem_write stays high 4 cycles; the FSM returns to FETCH; retired increments once.
REQ-034 FETCH with mem_ready low 2 cycles: ir_write=0 and pc_write=0 until the third cycle, then both are 1 for exactly one cycle.
REQ-035 opcode=6'h3F in DECODE: HALT is entered, illegal_op=1 persists for 10 cycles, and a reset pulse returns the FSM to FETCH with illegal_op=0.
REQ-036 Sequence R-type, addi, beq, j: total 14 cycles and retired=4; in BRANCH, pc_write_cond=1 with pc_source=1; in JUMP, pc_write=1 with pc_source=2.
REQ-037 Reset asserted asynchronously in MEMRD: state=0 immediately, with no reg_write afterward and retired unchanged.
